// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory wait
// freeze with timeout abort, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_ID_EX,
  input  logic [4:0]       rd_ID_EX,
  input  logic [4:0]       rs1_IF_ID,
  input  logic [4:0]       rs2_IF_ID,
  input  logic             uses_rs1_IF_ID,
  input  logic             uses_rs2_IF_ID,
  input  logic             branch_taken_EX,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              r_mem_timeout;
  logic              w_timeout_set;
  logic              w_mem_stall;
  logic              w_load_use;
  logic              w_stall_cnt_en;
  logic              w_flush_cnt_en;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_count;

  // Register x0 is hard-wired zero, so it can never carry a load-use dependency
  assign w_load_use = mem_read_ID_EX && (rd_ID_EX != 5'd0) &&
                      ((uses_rs1_IF_ID && (rd_ID_EX == rs1_IF_ID)) ||
                       (uses_rs2_IF_ID && (rd_ID_EX == rs2_IF_ID)));

  // Next-state logic for the memory-wait FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_set = 1'b0;
    w_mem_stall   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (dmem_req && !dmem_ready) begin
          w_state_nxt = S_MEM_WAIT;
          w_wcnt_nxt  = WCNT_W'(1);
          w_mem_stall = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready || !dmem_req) begin
          w_state_nxt = S_RUN;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == WCNT_W'(MEM_TIMEOUT)) begin
          // Abort the access: release the pipe and flag the error
          w_state_nxt   = S_RUN;
          w_wcnt_nxt    = '0;
          w_timeout_set = 1'b1;
        end else begin
          w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
          w_mem_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Pipeline control, priority: memory stall > branch flush > load-use > normal
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (w_mem_stall) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (branch_taken_EX) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (w_load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  assign w_stall_cnt_en = w_mem_stall || (!branch_taken_EX && w_load_use);
  assign w_flush_cnt_en = !w_mem_stall && branch_taken_EX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_RUN;
      r_wcnt         <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_timeout_set) r_mem_timeout <= 1'b1;
      if (w_stall_cnt_en && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flush_cnt_en && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
